// File: rtl/eq_mixer_pkg.sv
// Shared constants, FSM state type and the 24-bit saturation helper for the EQ band mixer.
package eq_mixer_pkg;

  localparam int unsigned SampleW   = 24;
  localparam int unsigned FirW      = 48;
  localparam int unsigned RoundBits = 14;

  localparam logic [15:0] GainUnity = 16'h4000;

  localparam logic signed [SampleW-1:0] SampleMax = 24'sh7fffff;
  localparam logic signed [SampleW-1:0] SampleMin = 24'sh800000;

  localparam logic [3:0] ClipClrSel = 4'hf;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StSat,
    StOut
  } mix_state_e;

  function automatic logic signed [SampleW-1:0] sat24(input logic signed [FirW-1:0] x);
    logic signed [FirW-1:0] hi;
    logic signed [FirW-1:0] lo;
    hi = FirW'(SampleMax);
    lo = FirW'(SampleMin);
    if (x > hi) begin
      return SampleMax;
    end else if (x < lo) begin
      return SampleMin;
    end
    return x[SampleW-1:0];
  endfunction

endpackage

// File: rtl/eq_channel_mac.sv
// One channel of the mixer: per-band sat24, gain multiply, accumulate, then round and saturate.
module eq_channel_mac
  import eq_mixer_pkg::*;
#(
  parameter int unsigned AccShift = 15,
  parameter int unsigned GainW    = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic                      mac_en_i,
  input  logic                      sat_en_i,
  input  logic                      zero_i,
  input  logic signed [FirW-1:0]    fir_i,
  input  logic signed [GainW-1:0]   gain_i,
  output logic signed [SampleW-1:0] data_o,
  output logic                      sat_hit_o
);

  localparam int unsigned ProdW = SampleW + GainW;
  // Three guard bits cover up to eight full-scale bands at maximum gain.
  localparam int unsigned AccW  = ProdW + 3;
  localparam logic signed [AccW-1:0] RoundHalf = AccW'(64'd1 << (RoundBits - 1));

  logic signed [FirW-1:0]    fir_scaled;
  logic signed [SampleW-1:0] sample;
  logic signed [ProdW-1:0]   term;
  logic signed [AccW-1:0]    acc_q, acc_d;
  logic signed [AccW-1:0]    rounded;
  logic signed [SampleW-1:0] y_sat;
  logic signed [SampleW-1:0] data_q, data_d;

  always_comb begin
    fir_scaled = fir_i >>> AccShift;
    sample     = sat24(fir_scaled);
    term       = ProdW'(sample) * ProdW'(gain_i);
    rounded    = (acc_q + RoundHalf) >>> RoundBits;
    y_sat      = sat24(FirW'(rounded));
  end

  always_comb begin
    acc_d  = acc_q;
    data_d = data_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + AccW'(term);
    end
    if (sat_en_i) begin
      data_d = y_sat;
    end
    if (zero_i) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q  <= '0;
      data_q <= '0;
    end else begin
      acc_q  <= acc_d;
      data_q <= data_d;
    end
  end

  assign data_o    = data_q;
  assign sat_hit_o = sat_en_i && (FirW'(rounded) != FirW'(y_sat));

endmodule

// File: rtl/eq_band_mixer.sv
// Snapshots the FIR bank's band accumulators on a fir_valid rising edge, applies per-band gains
// and mixes to 24-bit stereo. Define EQ_MIXER_CLIP_STATUS_EN for sticky clip status flags.
module eq_band_mixer
  import eq_mixer_pkg::*;
#(
  parameter int unsigned NumBands = 4,
  parameter int unsigned AccShift = 15,
  parameter int unsigned GainW    = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           audio_en_i,
  input  logic                           fir_valid_i,
  input  logic [NumBands-1:0][FirW-1:0]  l_fir_data_i,
  input  logic [NumBands-1:0][FirW-1:0]  r_fir_data_i,
  input  logic                           gain_wr_en_i,
  input  logic [3:0]                     gain_select_i,
  input  logic [GainW-1:0]               gain_wr_data_i,
  output logic [SampleW-1:0]             l_data_out_o,
  output logic [SampleW-1:0]             r_data_out_o,
  output logic                           data_out_en_o,
  output logic                           busy_o,
  output logic                           l_clip_o,
  output logic                           r_clip_o
);

  localparam int unsigned CntW = (NumBands > 1) ? $clog2(NumBands) : 1;

  mix_state_e                     state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic                           fir_valid_q;
  logic [NumBands-1:0][GainW-1:0] gain_q, gain_d;
  logic [NumBands-1:0][GainW-1:0] gain_snap_q;
  logic [NumBands-1:0][FirW-1:0]  l_snap_q, r_snap_q;
  logic                           frame_start, last_band, mac_en, sat_en;
  logic                           l_sat_hit, r_sat_hit;

  assign frame_start = fir_valid_i & ~fir_valid_q & audio_en_i & (state_q == StIdle);
  assign last_band   = (cnt_q == CntW'(NumBands - 1));

  always_comb begin
    gain_d = gain_q;
    for (int unsigned b = 0; b < NumBands; b++) begin
      if (gain_wr_en_i && (gain_select_i == 4'(b))) begin
        gain_d[b] = gain_wr_data_i;
      end
    end
  end

  // History resets high so a bank already valid at reset does not start a frame.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gain_q      <= {NumBands{GainW'(GainUnity)}};
      fir_valid_q <= 1'b1;
    end else begin
      gain_q      <= gain_d;
      fir_valid_q <= fir_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (frame_start) begin
      l_snap_q    <= l_fir_data_i;
      r_snap_q    <= r_fir_data_i;
      gain_snap_q <= gain_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StMac;
          cnt_d   = '0;
        end
      end
      StMac: begin
        cnt_d = cnt_q + CntW'(1);
        if (last_band) begin
          state_d = StSat;
        end
      end
      StSat:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (!audio_en_i) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    busy_o        = (state_q != StIdle);
    data_out_en_o = (state_q == StOut);
    mac_en        = (state_q == StMac);
    sat_en        = (state_q == StSat) & audio_en_i;
  end

  eq_channel_mac #(
    .AccShift (AccShift),
    .GainW    (GainW)
  ) u_l_mac (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (frame_start),
    .mac_en_i  (mac_en),
    .sat_en_i  (sat_en),
    .zero_i    (~audio_en_i),
    .fir_i     (l_snap_q[cnt_q]),
    .gain_i    (gain_snap_q[cnt_q]),
    .data_o    (l_data_out_o),
    .sat_hit_o (l_sat_hit)
  );

  eq_channel_mac #(
    .AccShift (AccShift),
    .GainW    (GainW)
  ) u_r_mac (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (frame_start),
    .mac_en_i  (mac_en),
    .sat_en_i  (sat_en),
    .zero_i    (~audio_en_i),
    .fir_i     (r_snap_q[cnt_q]),
    .gain_i    (gain_snap_q[cnt_q]),
    .data_o    (r_data_out_o),
    .sat_hit_o (r_sat_hit)
  );

`ifdef EQ_MIXER_CLIP_STATUS_EN
  logic l_clip_q, r_clip_q;
  logic clip_clr;

  assign clip_clr = gain_wr_en_i & (gain_select_i == ClipClrSel);

  // A saturation in the same cycle as a clear wins, so no clip event is lost.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      l_clip_q <= 1'b0;
      r_clip_q <= 1'b0;
    end else begin
      l_clip_q <= (l_clip_q & ~clip_clr) | l_sat_hit;
      r_clip_q <= (r_clip_q & ~clip_clr) | r_sat_hit;
    end
  end

  assign l_clip_o = l_clip_q;
  assign r_clip_o = r_clip_q;
`else
  logic unused_sat_hit;
  assign unused_sat_hit = l_sat_hit ^ r_sat_hit;
  assign l_clip_o       = 1'b0;
  assign r_clip_o       = 1'b0;
`endif

endmodule

// File: tb/tb_eq_band_mixer.sv
// Scoreboard bench for eq_band_mixer: expected samples queued at frame start, checked on strobe.
module tb_eq_band_mixer;
  import eq_mixer_pkg::*;

  localparam int NB = 4;

  logic                   clk = 1'b0;
  logic                   reset, audio_en, fir_valid, gain_wr_en;
  logic [3:0]             gain_select;
  logic [15:0]            gain_wr_data;
  logic [NB-1:0][47:0]    l_fir_data, r_fir_data;
  logic [23:0]            l_data_out, r_data_out;
  logic                   data_out_en, busy, l_clip, r_clip;

  logic signed [47:0] tb_l [NB];
  logic signed [47:0] tb_r [NB];
  logic signed [15:0] tb_gain [NB];

  int          err_cnt = 0;
  int          chk_cnt = 0;
  int          strobe_cnt = 0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;
  bit          exp_l_clip, exp_r_clip, clip_on;

  always #5 clk = ~clk;

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      l_fir_data[b] = tb_l[b];
      r_fir_data[b] = tb_r[b];
    end
  end

  eq_band_mixer u_dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .audio_en_i     (audio_en),
    .fir_valid_i    (fir_valid),
    .l_fir_data_i   (l_fir_data),
    .r_fir_data_i   (r_fir_data),
    .gain_wr_en_i   (gain_wr_en),
    .gain_select_i  (gain_select),
    .gain_wr_data_i (gain_wr_data),
    .l_data_out_o   (l_data_out),
    .r_data_out_o   (r_data_out),
    .data_out_en_o  (data_out_en),
    .busy_o         (busy),
    .l_clip_o       (l_clip),
    .r_clip_o       (r_clip)
  );

  task automatic check_val(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint clamp24(input longint v);
    if (v > 64'sd8388607) return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  function automatic longint model_chan(input bit left, output bit clipped);
    longint acc = 0;
    longint s, y;
    for (int b = 0; b < NB; b++) begin
      s = left ? longint'(tb_l[b]) : longint'(tb_r[b]);
      s = clamp24(s >>> 15);
      acc += s * longint'(tb_gain[b]);
    end
    y = (acc + 64'sd8192) >>> 14;
    clipped = (y != clamp24(y));
    return clamp24(y);
  endfunction

  task automatic push_expected();
    longint ly, ry;
    bit lc, rc;
    logic [47:0] e;
    ly = model_chan(1'b1, lc);
    ry = model_chan(1'b0, rc);
    e = {ly[23:0], ry[23:0]};
    exp_q.push_back(e);
    exp_l_clip |= lc;
    exp_r_clip |= rc;
  endtask

  task automatic set_bands(input longint l0, input longint l1, input longint l2, input longint l3,
                           input longint r0, input longint r1, input longint r2, input longint r3);
    tb_l[0] = 48'(l0 <<< 15);
    tb_l[1] = 48'(l1 <<< 15);
    tb_l[2] = 48'(l2 <<< 15);
    tb_l[3] = 48'(l3 <<< 15);
    tb_r[0] = 48'(r0 <<< 15);
    tb_r[1] = 48'(r1 <<< 15);
    tb_r[2] = 48'(r2 <<< 15);
    tb_r[3] = 48'(r3 <<< 15);
  endtask

  task automatic write_gain(input logic [3:0] sel, input logic [15:0] val);
    @(negedge clk);
    gain_wr_en   = 1'b1;
    gain_select  = sel;
    gain_wr_data = val;
    if (sel < NB) tb_gain[sel] = val;
    if (sel == 4'hf) begin
      exp_l_clip = 1'b0;
      exp_r_clip = 1'b0;
    end
    @(negedge clk);
    gain_wr_en = 1'b0;
  endtask

  // action: 0 plain, 1 fir_valid glitch while busy, 2 gain[0]=0 at T0+1, 3 audio_en drop at T0+2
  task automatic run_frame(input int action, input string tag);
    int lat;
    int n0;
    lat = -1;
    n0  = strobe_cnt;
    @(negedge clk);
    fir_valid = 1'b1;
    if (action != 3) push_expected();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (data_out_en === 1'b1 && lat < 0) lat = k;
      if (k == 1) check_val({tag, "_busy_t1"}, 48'(busy), 48'd1);
      if (action != 3 && k == NB + 3) check_val({tag, "_busy_after"}, 48'(busy), 48'd0);
      case (action)
        1: begin
          if (k == 2) fir_valid = 1'b0;
          else if (k == 3) fir_valid = 1'b1;
        end
        2: begin
          if (k == 1) begin
            gain_wr_en   = 1'b1;
            gain_select  = 4'd0;
            gain_wr_data = 16'h0000;
            tb_gain[0]   = 16'sh0000;
          end else if (k == 2) begin
            gain_wr_en = 1'b0;
          end
        end
        3: begin
          if (k == 2) begin
            audio_en = 1'b0;
          end else if (k == 3) begin
            check_val({tag, "_busy"}, 48'(busy), 48'd0);
            check_val({tag, "_en"}, 48'(data_out_en), 48'd0);
            check_val({tag, "_l_zero"}, 48'(l_data_out), 48'd0);
            check_val({tag, "_r_zero"}, 48'(r_data_out), 48'd0);
          end
        end
        default: ;
      endcase
    end
    if (action == 3) begin
      audio_en = 1'b1;
      check_val({tag, "_strobes"}, 48'(strobe_cnt - n0), 48'd0);
    end else begin
      check_val({tag, "_latency"}, 48'(lat), 48'(NB + 2));
      check_val({tag, "_strobes"}, 48'(strobe_cnt - n0), 48'd1);
    end
    check_val({tag, "_l_clip"}, 48'(l_clip), 48'(exp_l_clip & clip_on));
    check_val({tag, "_r_clip"}, 48'(r_clip), 48'(exp_r_clip & clip_on));
    fir_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && data_out_en === 1'b1) begin
      strobe_cnt++;
      check_val("strobe_expected", 48'(exp_q.size() != 0), 48'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_val("l_out", 48'(l_data_out), 48'(mon_e[47:24]));
        check_val("r_out", 48'(r_data_out), 48'(mon_e[23:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
`ifdef EQ_MIXER_CLIP_STATUS_EN
    clip_on = 1'b1;
`else
    clip_on = 1'b0;
`endif
    exp_l_clip   = 1'b0;
    exp_r_clip   = 1'b0;
    reset        = 1'b1;
    audio_en     = 1'b1;
    fir_valid    = 1'b1;
    gain_wr_en   = 1'b0;
    gain_select  = 4'd0;
    gain_wr_data = 16'h0000;
    for (int b = 0; b < NB; b++) begin
      tb_l[b]    = '0;
      tb_r[b]    = '0;
      tb_gain[b] = 16'sh4000;
    end
    repeat (3) @(negedge clk);
    check_val("rst_l_out", 48'(l_data_out), 48'd0);
    check_val("rst_r_out", 48'(r_data_out), 48'd0);
    check_val("rst_en", 48'(data_out_en), 48'd0);
    check_val("rst_busy", 48'(busy), 48'd0);
    check_val("rst_l_clip", 48'(l_clip), 48'd0);
    check_val("rst_r_clip", 48'(r_clip), 48'd0);
    reset = 1'b0;

    // Valid already high through reset must not start a frame.
    repeat (10) @(negedge clk);
    check_val("valid_at_reset_strobes", 48'(strobe_cnt), 48'd0);
    check_val("valid_at_reset_busy", 48'(busy), 48'd0);
    fir_valid = 1'b0;

    set_bands(1000, 0, 0, 0, 0, -500, 0, 0);
    run_frame(0, "unity");

    write_gain(4'd0, 16'h2000);
    set_bands(1000, 200, 0, 0, 0, 0, 0, 0);
    run_frame(0, "mix");

    set_bands(3, 0, 0, 0, 0, 0, 0, 0);
    run_frame(0, "rnd_pos");
    set_bands(-3, 0, 0, 0, 0, 0, 0, 0);
    run_frame(0, "rnd_neg");

    write_gain(4'd5, 16'h0000);
    write_gain(4'd0, 16'h4000);
    set_bands(8388607, 8388607, 8388607, 8388607, -8388608, -8388608, -8388608, -8388608);
    run_frame(0, "sat");

    // Out-of-range band is pre-saturated; output itself does not clip.
    set_bands(64'sd1 <<< 30, 0, 0, 0, -100, 0, 0, 0);
    run_frame(0, "presat");
    write_gain(4'hf, 16'h0000);
    check_val("clip_clr_l", 48'(l_clip), 48'd0);
    check_val("clip_clr_r", 48'(r_clip), 48'd0);

    set_bands(1234, 0, 0, 0, 0, 0, 0, -321);
    run_frame(1, "glitch");
    set_bands(77, 0, 0, 0, 0, 0, 0, 55);
    run_frame(3, "abort");
    run_frame(0, "after_abort");

    write_gain(4'd2, 16'hc000);
    set_bands(1000, 0, 40, 0, 0, 0, 0, -2000);
    run_frame(2, "snap");
    run_frame(0, "snap_next");

    repeat (2) @(negedge clk);
    check_val("queue_empty", 48'(exp_q.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/eq_band_mixer.md
Name: eq_band_mixer

Overview:
- Consumer end of the FIR filter bank's output interface. Waits for the bank's data_valid to rise, then snapshots every band's 48-bit left/right accumulator.
- Applies a programmable per-band gain, sums the bands, then rounds and saturates to 24-bit stereo samples.
- Emits one output strobe per audio frame toward the I2S/DAC output path.

Parameters:
- NUM_BANDS, 4, number of FIR bands (1..8); must match the filter bank's band count.
- ACC_SHIFT, 15, right shift that returns a FIR accumulator (24b data x Q1.15 coef) to 24-bit sample scale.
- GAIN_W, 16, gain width, signed Q2.14 (16'h4000 = 1.0).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- audio_en  in  1  audio path enable; low forces idle
- fir_valid  in  1  FIR bank data_valid (level; rising edge = new frame ready)
- l_fir_data  in  48 x NUM_BANDS  left band accumulators
- r_fir_data  in  48 x NUM_BANDS  right band accumulators
- gain_wr_en  in  1  gain write strobe
- gain_select  in  4  band index for the write
- gain_wr_data  in  GAIN_W  signed Q2.14 gain
- l_data_out  out  24  mixed left sample, signed
- r_data_out  out  24  mixed right sample, signed
- data_out_en  out  1  one-cycle strobe; l/r outputs are valid when it is high
- busy  out  1  high while a frame is being processed
- l_clip  out  1  left saturation status (see Optional Feature)
- r_clip  out  1  right saturation status

Behaviour:
- Reset: gains = 16'h4000 for all bands; l/r_data_out = 0; data_out_en = 0; busy = 0; clip flags = 0; state = IDLE; fir_valid history register = 1.
  - History = 1 means a bank that is already valid at reset does not trigger a spurious frame.
- Gain write: when gain_wr_en=1 and gain_select < NUM_BANDS, gain[gain_select] <= gain_wr_data on that clk. Writes with gain_select >= NUM_BANDS are ignored. Writes are accepted in any state.
- Frame start:
  - Condition: fir_valid=1 with previous fir_valid=0, audio_en=1, and state IDLE. Call this edge T0.
  - At T0, all band data and all gains are snapshotted into local registers. Gain writes after T0 affect the next frame only.
  - A rising edge while busy is ignored; no queueing.
- FSM:
  - IDLE -> MAC on frame start. Band counter = 0, accumulators = 0.
  - MAC: one band per cycle, left and right in parallel, for NUM_BANDS cycles.
    - term = sat24(fir >>> ACC_SHIFT) * gain. This is a 24x16 signed product, 40 bits.
    - acc += term, with acc 43 bits wide.
    - Leaves for SAT after band NUM_BANDS-1.
  - SAT: y = (acc + 2^13) >>> 14, i.e. round half toward +inf. Saturate y to [-8388608, 8388607]. Register the result into l/r_data_out.
  - OUT: data_out_en = 1 for exactly this cycle -> IDLE.
- Timing:
  - data_out_en is high in the cycle NUM_BANDS+2 clocks after T0 (6 clocks for the default).
  - busy is high from T0+1 through the OUT cycle inclusive.
  - l/r_data_out hold their value until the next SAT.
- audio_en low in any state: next clk -> IDLE, data_out_en = 0, l/r_data_out = 0, busy = 0. Gains and clip flags are retained.
- Reset asserted mid-frame: all reset values apply on that clk. No strobe is emitted for the aborted frame.
- Per-band pre-saturation sat24 prevents overflow from out-of-range FIR accumulators. Accumulator headroom is sufficient for NUM_BANDS <= 8 at maximum gain.

Optional Feature:
- Macro: EQ_MIXER_CLIP_STATUS_EN.
- With the macro:
  - l_clip/r_clip are sticky. Each is set in the SAT cycle when that channel's output saturates.
  - Both are cleared together by a gain write with gain_select = 4'hF, and by reset.
- Without the macro: l_clip = r_clip = 0 constantly, and no clip logic is synthesised.

Decomposition:
- Package eq_mixer_pkg:
  - GAIN_UNITY = 16'h4000.
  - Fractional bits ROUND_BITS = 14.
  - SAMPLE_MAX/SAMPLE_MIN 24-bit constants.
  - State enum {IDLE, MAC, SAT, OUT}.
  - Clip-clear select constant 4'hF.
- Sub-module eq_channel_mac: one channel's sat24, multiply, accumulate, round and saturate. It is instantiated for left and right under the shared FSM and band counter in eq_band_mixer.

Test Plan:
- Unity pass-through: after reset, l_fir_data[0] = 1000<<15, other bands 0, r_fir_data[1] = -500<<15; raise fir_valid -> 6 clocks later data_out_en pulses once with l=1000, r=-500, busy low the next cycle.
- Gain mix: gain[0] = 16'h2000, l_fir_data[0] = 1000<<15, l_fir_data[1] = 200<<15 -> l_data_out = 700.
- Rounding: gain[0] = 16'h2000, l_fir_data[0] = 3<<15 -> 2; with -3<<15 -> -1.
- Saturation: all four bands 8388607<<15 at unity -> l_data_out = 24'h7FFFFF, l_clip = 1 (with macro), still 1 after the next clean frame; gain write select 4'hF clears it. Same test negative -> 24'h800000.
- Edge handling:
  - Hold fir_valid high across frames -> only one strobe.
  - Toggle fir_valid while busy -> ignored.
  - Drop audio_en at T0+2 -> no strobe, outputs 0, IDLE.
- Gain snapshot: write gain[0] = 0 at T0+1 -> current frame still uses unity; next frame output = 0.
